alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Synchronous front end that issues operations to the 32-bit ripple ALU (fullbitalu) and collects its results. It accepts a command (opcode, operands, carry-in) over a valid/ready handshake and drives the ALU control and operand lines from registers. It holds them for a fixed settle window that covers the ripple-carry path, captures f/cout/zero/set, and returns a result over a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.
SETTLE, 4, cycles operands are held before capture; legal range 1..255.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept
cmd_op  input  3  opcode {sub,s1,s2}: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
cmd_a  input  WIDTH  operand a
cmd_b  input  WIDTH  operand b
cmd_cin  input  1  carry-in (ADD only; ORed with sub inside the ALU)
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_s1  output  1  to ALU s1
alu_s2  output  1  to ALU s2
alu_sub  output  1  to ALU sub
alu_cin  output  1  to ALU cin
alu_f  input  WIDTH  from ALU f
alu_cout  input  1  from ALU cout
alu_zero  input  1  from ALU zero
alu_set  input  1  from ALU set
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  WIDTH  result; SLT gives {WIDTH-1 zeros, set}, other ops give alu_f
rsp_cout  output  1  captured alu_cout
rsp_zero  output  1  captured alu_zero (raw f, so SUB zero = equality)
rsp_err  output  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state IDLE, cmd_ready=1, rsp_valid=0.
  - all alu_* outputs 0, so the ALU idles in AND with zero operands.
  - rsp_data=0, rsp_cout=0, rsp_zero=0, rsp_err=0.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: register cmd_a/b into alu_a/b, decode cmd_op into alu_s1/s2/sub, register alu_cin = cmd_cin & (op==010).
  - Load the counter with SETTLE-1, latch the SLT indicator, go to DRIVE.
- DRIVE:
  - cmd_ready=0; all alu_* outputs held stable.
  - Counter decrements each edge.
  - On the edge where counter==0: capture rsp_data/rsp_cout/rsp_zero, assert rsp_valid, go to RESP.
  - rsp_valid therefore rises exactly SETTLE edges after the accept edge.
- RESP:
  - rsp_valid=1; rsp_* outputs stable until handshake.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - alu_* outputs keep their last values and rsp_* keep their captured values.
- Throughput and backpressure:
  - One operation per SETTLE+2 cycles minimum; commands never overlap.
  - rsp_ready held low stalls indefinitely in RESP with no data change.
  - cmd_valid is ignored outside IDLE.
- Reset mid-operation: any state returns to IDLE with all reset values on the next edge. An in-flight result is discarded and never presented.
- Width rules:
  - No arithmetic in this block; the only arithmetic element is the counter, 8 bits wide.
  - The SLT result is zero-extended.
  - cout is reported unmodified for every op.

Optional Feature:
Macro ALU_SEQ_OPCHECK_EN.
- Defined:
  - Opcodes 011, 100 and 101 are illegal. An illegal command is accepted, skips DRIVE, and enters RESP on the next edge with rsp_data=0, rsp_cout=0, rsp_zero=0, rsp_err=1.
  - alu_* outputs are not updated for an illegal command.
  - Legal commands give rsp_err=0.
- Not defined:
  - rsp_err is tied 0.
  - Every opcode drives the ALU raw through the normal DRIVE path; for example 011 behaves as ADD per the ALU mux.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode localparams (OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111).
  - state encoding (IDLE=2'd0, DRIVE=2'd1, RESP=2'd2).
  - SETTLE bounds.
- One combinational sub-module, alu_op_decode: cmd_op -> s1, s2, sub, is_slt, legal.

Test Plan:
1. Reset sequence: assert rst for 2 cycles mid-DRIVE -> next edge has cmd_ready=1, rsp_valid=0, all alu_*=0, and no response ever appears.
2. ADD a=2, b=3, cin=0, SETTLE=4 -> alu_s1=1, alu_s2=0, alu_sub=0. rsp_valid rises 4 edges after accept with rsp_data=5, rsp_cout=0, rsp_zero=0.
3. SUB a=3, b=3 -> rsp_data=0, rsp_zero=1, rsp_cout=1. Then SLT a=55, b=67 -> rsp_data=1. Then SLT a=151, b=42 -> rsp_data=0.
4. Backpressure: AND a=5, b=4 with rsp_ready=0 for 10 cycles -> rsp_valid stays 1 and rsp_data stays 4. cmd_valid pulsed during the stall is not accepted (cmd_ready=0). rsp_ready=1 -> IDLE on the next edge.
5. Carry-in masking: OR a=2, b=1, cin=1 -> alu_cin=0, rsp_data=3. ADD a=2, b=6, cin=1 -> rsp_data=9.
6. Illegal op 100, a=1, b=1: with ALU_SEQ_OPCHECK_EN -> rsp_err=1, rsp_data=0 one edge after accept, alu_* unchanged. Without the macro -> normal SETTLE latency and rsp_err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode values, FSM state encoding and settle-window
// bounds for the ALU operation sequencer.
package alu_seq_pkg;

    // Opcode layout is {sub, s1, s2}
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Settle window is counted by an 8-bit down-counter
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: splits a sequencer opcode into ALU control lines.
// With ALU_SEQ_OPCHECK_EN defined, opcodes 011/100/101 are flagged illegal;
// otherwise every opcode is reported legal and drives the ALU raw.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    output logic       s1,
    output logic       s2,
    output logic       sub,
    output logic       is_slt,
    output logic       legal
);

    assign sub    = op[2];
    assign s1     = op[1];
    assign s2     = op[0];
    assign is_slt = (op == OP_SLT);

`ifdef ALU_SEQ_OPCHECK_EN
    assign legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_SLT);
`else
    assign legal = 1'b1;
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts a command, drives the ripple ALU from registers
// for SETTLE cycles, captures its outputs and returns them over valid/ready.
// Optional opcode checking is enabled with ALU_SEQ_OPCHECK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds with its data stable until that edge.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4     // SETTLE_MIN..SETTLE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic             alu_sub,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_set,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               slt_q;

    logic dec_s1, dec_s2, dec_sub, dec_slt, dec_legal;

    alu_op_decode u_decode (
        .op     (cmd_op),
        .s1     (dec_s1),
        .s2     (dec_s2),
        .sub    (dec_sub),
        .is_slt (dec_slt),
        .legal  (dec_legal)
    );

`ifdef ALU_SEQ_OPCHECK_EN
    logic err_q;
    logic ill_q;   // current command is illegal: respond with zeros and err
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Sequencer FSM: accept, hold operands for the settle window, capture, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            cnt       <= '0;
            slt_q     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s1    <= 1'b0;
            alu_s2    <= 1'b0;
            alu_sub   <= 1'b0;
            alu_cin   <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_zero  <= 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
            err_q     <= 1'b0;
            ill_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        state     <= DRIVE;
                        if (dec_legal) begin
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                            alu_s1  <= dec_s1;
                            alu_s2  <= dec_s2;
                            alu_sub <= dec_sub;
                            alu_cin <= cmd_cin & (cmd_op == OP_ADD);
                            slt_q   <= dec_slt;
                            cnt     <= CNT_LOAD;
`ifdef ALU_SEQ_OPCHECK_EN
                            ill_q   <= 1'b0;
`endif
                        end else begin
                            // ALU lines untouched; answer on the very next edge
                            cnt     <= '0;
`ifdef ALU_SEQ_OPCHECK_EN
                            ill_q   <= 1'b1;
`endif
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef ALU_SEQ_OPCHECK_EN
                        if (ill_q) begin
                            rsp_data <= '0;
                            rsp_cout <= 1'b0;
                            rsp_zero <= 1'b0;
                            err_q    <= 1'b1;
                        end else
`endif
                        begin
                            rsp_data <= slt_q ? {{(WIDTH-1){1'b0}}, alu_set} : alu_f;
                            rsp_cout <= alu_cout;
                            rsp_zero <= alu_zero;
`ifdef ALU_SEQ_OPCHECK_EN
                            err_q    <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a behavioural
// ALU attached and a timestamp/queue reference model checked every cycle.
// Honours ALU_SEQ_OPCHECK_EN the same way the design does.
module tb_alu_op_sequencer;
  localparam int W      = 32;
  localparam int SETTLE = 4;
  localparam int AW     = 2 * W + 4;
  localparam int RW     = W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'b000;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_cin = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic         alu_s1, alu_s2, alu_sub, alu_cin;
  logic         alu_cout, alu_zero, alu_set;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_cout, rsp_zero, rsp_err;

  alu_op_sequencer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_sub(alu_sub), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_set(alu_set),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // ---------------- behavioural ALU (fullbitalu) ----------------
  // returns {cout, set, f}; b is inverted when sub, carry-in is cin|sub
  function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s1, input logic s2,
                                          input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic [W-1:0] f;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (cin | sub)};
    if (s1)      f = sum[W-1:0];
    else if (s2) f = a | bb;
    else         f = a & bb;
    return {sum[W], sum[W-1], f};
  endfunction

  logic [W+1:0] alu_out;
  assign alu_out  = alu_fn(alu_a, alu_b, alu_s1, alu_s2, alu_sub, alu_cin);
  assign alu_f    = alu_out[W-1:0];
  assign alu_set  = alu_out[W];
  assign alu_cout = alu_out[W+1];
  assign alu_zero = (alu_out[W-1:0] == '0);

  // ---------------- reference model ----------------
  function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SEQ_OPCHECK_EN
    return !(op == 3'b011 || op == 3'b100 || op == 3'b101);
`else
    return 1'b1;
`endif
  endfunction

  // expected {err, zero, cout, data} for a command
  function automatic logic [RW-1:0] exp_resp(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic cin);
    logic [W+1:0] r;
    logic [W-1:0] d;
    if (!op_legal(op)) return {1'b1, 1'b0, 1'b0, {W{1'b0}}};
    r = alu_fn(a, b, op[1], op[0], op[2], cin && (op == 3'b010));
    d = (op == 3'b111) ? {{(W-1){1'b0}}, r[W]} : r[W-1:0];
    return {1'b0, (r[W-1:0] == '0), r[W+1], d};
  endfunction

  logic [RW-1:0] exp_q[$];
  logic [AW-1:0] m_alu  = '0;
  logic [RW-1:0] m_rsp  = '0;
  logic          m_busy = 1'b0;
  logic          m_rvalid = 1'b0;
  int            cyc = 0;
  int            m_due = 0;

  // model: response due SETTLE edges after accept (one edge if illegal)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy   <= 1'b0;
      m_rvalid <= 1'b0;
      m_alu    <= '0;
      m_rsp    <= '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1;
        m_due  <= cyc + (op_legal(cmd_op) ? SETTLE : 1);
        exp_q.push_back(exp_resp(cmd_op, cmd_a, cmd_b, cmd_cin));
        if (op_legal(cmd_op))
          m_alu <= {cmd_a, cmd_b, cmd_op[1], cmd_op[0], cmd_op[2],
                    cmd_cin && (cmd_op == 3'b010)};
      end
    end else if (!m_rvalid) begin
      if (cyc == m_due) begin
        m_rvalid <= 1'b1;
        m_rsp    <= exp_q[0];
      end
    end else if (rsp_ready) begin
      m_rvalid <= 1'b0;
      m_busy   <= 1'b0;
      void'(exp_q.pop_front());
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", AW'(cmd_ready), AW'(!m_busy));
      chk("rsp_valid", AW'(rsp_valid), AW'(m_rvalid));
      chk("alu_lines", {alu_a, alu_b, alu_s1, alu_s2, alu_sub, alu_cin}, m_alu);
      chk("rsp_fields", AW'({rsp_err, rsp_zero, rsp_cout, rsp_data}), AW'(m_rsp));
      if (m_rvalid && exp_q.size() > 0)
        chk("rsp_queue", AW'({rsp_err, rsp_zero, rsp_cout, rsp_data}), AW'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: cmd_ready got 0 expected 1");
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // edges from accept edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      if (lat > 500) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
        break;
      end
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_d);
    int lat;
    send(op, a, b, cin);
    wait_rsp(lat);
    chk({name, "_lat"}, AW'(lat), AW'(SETTLE));
    chk({name, "_data"}, AW'(rsp_data), AW'(exp_d));
    finish_rsp();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // reset values
    @(negedge clk);
    chk("reset_cmd_ready", AW'(cmd_ready), AW'(1));
    chk("reset_rsp_valid", AW'(rsp_valid), AW'(0));
    chk("reset_alu", {alu_a, alu_b, alu_s1, alu_s2, alu_sub, alu_cin}, '0);
    chk("reset_rsp", AW'({rsp_err, rsp_zero, rsp_cout, rsp_data}), '0);

    // reset in the middle of DRIVE
    send(3'b010, 32'd7, 32'd9, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cmd_ready", AW'(cmd_ready), AW'(1));
    chk("midrst_rsp_valid", AW'(rsp_valid), AW'(0));
    chk("midrst_alu", {alu_a, alu_b, alu_s1, alu_s2, alu_sub, alu_cin}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", AW'(seen), AW'(0));

    // ADD 2+3
    send(3'b010, 32'd2, 32'd3, 1'b0);
    chk("add_s1", AW'(alu_s1), AW'(1));
    chk("add_s2", AW'(alu_s2), AW'(0));
    chk("add_sub", AW'(alu_sub), AW'(0));
    wait_rsp(lat);
    chk("add_lat", AW'(lat), AW'(4));
    chk("add_data", AW'(rsp_data), AW'(5));
    chk("add_cout", AW'(rsp_cout), AW'(0));
    chk("add_zero", AW'(rsp_zero), AW'(0));
    finish_rsp();

    // SUB equal operands, then SLT both ways
    send(3'b110, 32'd3, 32'd3, 1'b0);
    wait_rsp(lat);
    chk("sub_data", AW'(rsp_data), AW'(0));
    chk("sub_zero", AW'(rsp_zero), AW'(1));
    chk("sub_cout", AW'(rsp_cout), AW'(1));
    finish_rsp();
    run_op("slt_lt", 3'b111, 32'd55, 32'd67, 1'b0, 32'd1);
    run_op("slt_ge", 3'b111, 32'd151, 32'd42, 1'b0, 32'd0);

    // backpressure with a command pulsed during the stall
    send(3'b000, 32'd5, 32'd4, 1'b0);
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      cmd_op = 3'b001; cmd_a = 32'd9; cmd_b = 32'd6;
      cmd_valid = (i % 3 == 1);
      @(negedge clk);
      chk("stall_valid", AW'(rsp_valid), AW'(1));
      chk("stall_data", AW'(rsp_data), AW'(4));
      chk("stall_cmd_ready", AW'(cmd_ready), AW'(0));
    end
    cmd_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    chk("release_cmd_ready", AW'(cmd_ready), AW'(1));
    chk("release_rsp_valid", AW'(rsp_valid), AW'(0));

    // carry-in masking
    send(3'b001, 32'd2, 32'd1, 1'b1);
    chk("or_cin_masked", AW'(alu_cin), AW'(0));
    wait_rsp(lat);
    chk("or_data", AW'(rsp_data), AW'(3));
    finish_rsp();
    send(3'b010, 32'd2, 32'd6, 1'b1);
    chk("add_cin_kept", AW'(alu_cin), AW'(1));
    wait_rsp(lat);
    chk("addc_data", AW'(rsp_data), AW'(9));
    finish_rsp();

    // opcode 100
    send(3'b100, 32'd1, 32'd1, 1'b0);
    wait_rsp(lat);
`ifdef ALU_SEQ_OPCHECK_EN
    chk("ill_lat", AW'(lat), AW'(1));
    chk("ill_err", AW'(rsp_err), AW'(1));
    chk("ill_data", AW'(rsp_data), AW'(0));
    chk("ill_alu_a", AW'(alu_a), AW'(2));
    chk("ill_alu_b", AW'(alu_b), AW'(6));
`else
    chk("op100_lat", AW'(lat), AW'(SETTLE));
    chk("op100_err", AW'(rsp_err), AW'(0));
    chk("op100_alu_sub", AW'(alu_sub), AW'(1));
`endif
    finish_rsp();
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
